// File: rtl/ext_irq_pkg.sv
// Shared constants for the external interrupt controller: register word
// indices (byte offset >> 2), trigger mode encoding and ID width helper.
package ext_irq_pkg;

    localparam logic [5:0] REG_PENDING   = 6'h00;  // byte 0x00
    localparam logic [5:0] REG_ENABLE    = 6'h01;  // byte 0x04
    localparam logic [5:0] REG_MODE      = 6'h02;  // byte 0x08
    localparam logic [5:0] REG_THRESHOLD = 6'h03;  // byte 0x0C
    localparam logic [5:0] REG_CLAIM     = 6'h04;  // byte 0x10
    localparam logic [5:0] REG_PRIO_BASE = 6'h08;  // byte 0x20

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } irq_mode_e;

    // Width of a source ID, with ID 0 reserved for "none".
    function automatic int unsigned id_width(input int unsigned num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/ext_irq_src_cell.sv
// Per-source slice: synchroniser, edge detect, pending and in-service state.
module ext_irq_src_cell
    import ext_irq_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      src,
    input  irq_mode_e mode,
    input  logic      enable,
    input  logic      prio_ok,
    input  logic      claim,
    input  logic      complete,
    output logic      pending,
    output logic      in_service,
    output logic      eligible
);

    logic s1;
    logic s2;
    logic s2_d;
    logic rise;
    logic pending_next;

    assign rise = s2 & ~s2_d;

    // Next pending: edge mode latches rises (a rise beats a claim clear);
    // level mode tracks the line but is forced low while in service.
    always_comb begin
        pending_next = pending;
        if (mode == MODE_EDGE) begin
            if (rise) begin
                pending_next = 1'b1;
            end else if (claim) begin
                pending_next = 1'b0;
            end
        end else begin
            pending_next = (claim || in_service) ? 1'b0 : s2;
        end
    end

    // Synchroniser, pending and in-service registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s2_d       <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            s1      <= src;
            s2      <= s1;
            s2_d    <= s2;
            pending <= pending_next;
            if (claim) begin
                in_service <= 1'b1;
            end else if (complete) begin
                in_service <= 1'b0;
            end
        end
    end

    assign eligible = enable & pending & ~in_service & prio_ok;

endmodule

// File: rtl/ext_irq_controller.sv
// Machine-level external interrupt controller: register file, bus decode,
// per-source cells and a priority arbiter producing the claimable winner.
module ext_irq_controller
    import ext_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 8,
    parameter int unsigned PRIO_W   = 3,
    parameter logic [31:0] BASE_ADR = 32'h0000_4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic [31:0]        adr,
    input  logic [31:0]        d_in,
    input  logic               mrd,
    input  logic               mwr,
    output logic [31:0]        d_out,
    output logic               machine_external_interrupt
);

    localparam int unsigned ID_W = id_width(NUM_SRC);

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  prio [NUM_SRC];

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] prio_ok;
    logic [NUM_SRC-1:0] claim;
    logic [NUM_SRC-1:0] complete;

    logic [ID_W-1:0]    winner;
    logic [PRIO_W-1:0]  best;

    logic               sel;
    logic [5:0]         word;
    logic               wr_en;
    logic               claim_en;
    logic               unused_bits;

    assign sel      = (adr[31:8] == BASE_ADR[31:8]);
    assign word     = adr[7:2];
    assign wr_en    = sel & mwr;
    // A simultaneous write suppresses the claim side effect.
    assign claim_en = sel & mrd & ~mwr & (word == REG_CLAIM);
    assign unused_bits = &{1'b0, adr[1:0], d_in};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign prio_ok[g]  = (prio[g] > threshold);
        assign claim[g]    = claim_en && (winner == ID_W'(g + 1));
        assign complete[g] = wr_en && (word == REG_CLAIM) && (d_in[4:0] == 5'(g + 1));

        ext_irq_src_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .src        (src[g]),
            .mode       (irq_mode_e'(mode[g])),
            .enable     (enable[g]),
            .prio_ok    (prio_ok[g]),
            .claim      (claim[g]),
            .complete   (complete[g]),
            .pending    (pending[g]),
            .in_service (in_service[g]),
            .eligible   (eligible[g])
        );
    end

    // Linear scan; strict '>' keeps the lowest ID on ties. Eligible implies
    // priority > threshold >= 0, so best starting at 0 needs no extra flag.
    always_comb begin
        winner = '0;
        best   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (prio[i] > best)) begin
                winner = ID_W'(i + 1);
                best   = prio[i];
            end
        end
    end

    // Register file writes and the registered interrupt request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enable    <= '0;
            mode      <= '0;
            threshold <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                prio[i] <= '0;
            end
            machine_external_interrupt <= 1'b0;
        end else begin
            machine_external_interrupt <= (winner != '0);
            if (wr_en) begin
                case (word)
                    REG_ENABLE:    enable    <= d_in[NUM_SRC-1:0];
                    REG_MODE:      mode      <= d_in[NUM_SRC-1:0];
                    REG_THRESHOLD: threshold <= d_in[PRIO_W-1:0];
                    default: begin
                        for (int unsigned i = 0; i < NUM_SRC; i++) begin
                            if (word == REG_PRIO_BASE + 6'(i)) begin
                                prio[i] <= d_in[PRIO_W-1:0];
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Read mux; zero unless selected and read-strobed.
    always_comb begin
        d_out = '0;
        if (sel && mrd) begin
            case (word)
                REG_PENDING:   d_out[NUM_SRC-1:0] = pending;
                REG_ENABLE:    d_out[NUM_SRC-1:0] = enable;
                REG_MODE:      d_out[NUM_SRC-1:0] = mode;
                REG_THRESHOLD: d_out[PRIO_W-1:0]  = threshold;
                REG_CLAIM:     d_out[ID_W-1:0]    = winner;
                default: begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (word == REG_PRIO_BASE + 6'(i)) begin
                            d_out[PRIO_W-1:0] = prio[i];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_irq_controller.sv
// Directed and randomized bench for ext_irq_controller against a
// cycle-level reference model of the documented controller rules.
module tb_ext_irq_controller;

    localparam int unsigned N    = 8;
    localparam int unsigned PW   = 3;
    localparam logic [31:0] BASE = 32'h0000_4000;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src;
    logic [31:0]  adr;
    logic [31:0]  d_in;
    logic         mrd;
    logic         mwr;
    logic [31:0]  d_out;
    logic         irq;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Reference model state
    bit [N-1:0] m_pend;
    bit [N-1:0] m_insvc;
    bit [N-1:0] m_en;
    bit [N-1:0] m_mode;
    int         m_prio [N];
    int         m_thr;
    bit         m_irq;
    bit [N-1:0] d1, d2, d3;   // src delayed by 1, 2, 3 clock edges

    ext_irq_controller #(
        .NUM_SRC  (N),
        .PRIO_W   (PW),
        .BASE_ADR (BASE)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .src                        (src),
        .adr                        (adr),
        .d_in                       (d_in),
        .mrd                        (mrd),
        .mwr                        (mwr),
        .d_out                      (d_out),
        .machine_external_interrupt (irq)
    );

    always #5 clk = ~clk;

    // Winner: maximise priority*64 - index over eligible sources.
    function automatic int model_winner();
        int best;
        int id;
        int score;
        best = -1000;
        id   = 0;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && m_pend[i] && !m_insvc[i] && m_prio[i] > m_thr) begin
                score = m_prio[i] * 64 - i;
                if (score > best) begin
                    best = score;
                    id   = i + 1;
                end
            end
        end
        return id;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, logic rd);
        int off;
        logic [31:0] v;
        v   = '0;
        off = int'(a[7:0]) & 'hFC;
        if (rd && a[31:8] == BASE[31:8]) begin
            if (off == 0)         v = 32'(m_pend);
            else if (off == 4)    v = 32'(m_en);
            else if (off == 8)    v = 32'(m_mode);
            else if (off == 'hC)  v = 32'(m_thr);
            else if (off == 'h10) v = 32'(model_winner());
            else if (off >= 'h20 && off < 'h20 + 4 * N) v = 32'(m_prio[(off - 'h20) / 4]);
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        bit sel;
        int off;
        int w;
        int claim_id;
        int cid;
        int comp_id;
        bit rise;
        if (!rst) begin
            m_pend = '0; m_insvc = '0; m_en = '0; m_mode = '0;
            for (int i = 0; i < N; i++) m_prio[i] = 0;
            m_thr = 0; m_irq = 0; d1 = '0; d2 = '0; d3 = '0;
            return;
        end
        sel      = (adr[31:8] == BASE[31:8]);
        off      = int'(adr[7:0]) & 'hFC;
        w        = model_winner();
        claim_id = (sel && mrd && !mwr && off == 'h10) ? w : 0;
        cid      = int'(d_in[4:0]);
        comp_id  = (sel && mwr && off == 'h10 && cid >= 1 && cid <= N) ? cid : 0;
        for (int i = 0; i < N; i++) begin
            rise = d2[i] && !d3[i];
            if (m_mode[i]) m_pend[i] = rise || (m_pend[i] && claim_id != i + 1);
            else           m_pend[i] = (claim_id == i + 1 || m_insvc[i]) ? 1'b0 : d2[i];
            if (claim_id == i + 1)     m_insvc[i] = 1'b1;
            else if (comp_id == i + 1) m_insvc[i] = 1'b0;
        end
        if (sel && mwr) begin
            if (off == 4)        m_en   = d_in[N-1:0];
            else if (off == 8)   m_mode = d_in[N-1:0];
            else if (off == 'hC) m_thr  = int'(d_in[PW-1:0]);
            else if (off >= 'h20 && off < 'h20 + 4 * N) m_prio[(off - 'h20) / 4] = int'(d_in[PW-1:0]);
        end
        m_irq = (w != 0);
        d3 = d2;
        d2 = d1;
        d1 = src;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic wr(int unsigned off, logic [31:0] v);
        adr  = BASE + 32'(off);
        d_in = v;
        mrd  = 1'b0;
        mwr  = 1'b1;
        tick();
        mwr  = 1'b0;
    endtask

    task automatic rd(string tag, int unsigned off, output logic [31:0] v);
        adr = BASE + 32'(off);
        mwr = 1'b0;
        mrd = 1'b1;
        #1;
        v = d_out;
        check(tag, d_out, model_read(adr, mrd));
        tick();
        mrd = 1'b0;
    endtask

    logic [31:0] v;
    logic [7:0]  offs [12];

    initial begin
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14,
                 8'h20, 8'h24, 8'h2C, 8'h3C, 8'h40, 8'hFC};
        rst = 1'b0; src = '1; adr = '0; d_in = '0; mrd = 1'b0; mwr = 1'b0;

        // Reset with all sources asserted
        idle(2);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        src = '0;
        rd("rst_pend", 'h00, v);  check("rst_pend_c", v, 32'd0);
        rd("rst_en",   'h04, v);  check("rst_en_c",   v, 32'd0);
        rd("rst_mode", 'h08, v);
        rd("rst_thr",  'h0C, v);
        rd("rst_prio", 'h20, v);  check("rst_prio_c", v, 32'd0);

        // Minimum latency, level mode
        wr('h04, 32'h01);
        wr('h20, 32'h1);
        wr('h08, 32'h0);
        src[0] = 1'b1;
        idle(3);
        check("lat3", 32'(irq), 32'd0);
        tick();
        check("lat4", 32'(irq), 32'd1);
        rd("claim_l", 'h10, v);   check("claim_l_c", v, 32'd1);
        src[0] = 1'b0;
        idle(3);
        wr('h10, 32'd1);
        idle(2);

        // Priority order with tie broken by lowest ID
        wr('h28, 32'd5);
        wr('h34, 32'd5);
        wr('h24, 32'd7);
        wr('h04, 32'h26);
        src[1] = 1'b1; src[2] = 1'b1; src[5] = 1'b1;
        idle(5);
        rd("claim_a", 'h10, v);   check("claim_a_c", v, 32'd2);
        src[1] = 1'b0; idle(3); wr('h10, 32'd2); idle(2);
        rd("claim_b", 'h10, v);   check("claim_b_c", v, 32'd3);
        src[2] = 1'b0; idle(3); wr('h10, 32'd3); idle(2);
        rd("claim_c", 'h10, v);   check("claim_c_c", v, 32'd6);
        src[5] = 1'b0; idle(3); wr('h10, 32'd6); idle(2);

        // Threshold gating
        wr('h04, 32'h08);
        wr('h2C, 32'd4);
        wr('h0C, 32'd4);
        src[3] = 1'b1;
        idle(5);
        check("thr_irq0", 32'(irq), 32'd0);
        rd("thr_claim0", 'h10, v); check("thr_claim0_c", v, 32'd0);
        wr('h0C, 32'd3);
        tick();
        check("thr_irq1", 32'(irq), 32'd1);
        rd("thr_claim", 'h10, v);  check("thr_claim_c", v, 32'd4);
        src[3] = 1'b0; idle(3); wr('h10, 32'd4); idle(2);
        wr('h0C, 32'd0);

        // Edge mode: re-pend while in service, eligible after complete
        wr('h08, 32'h01);
        wr('h04, 32'h01);
        src[0] = 1'b1;
        idle(5);
        rd("edge_claim1", 'h10, v); check("edge_claim1_c", v, 32'd1);
        src[0] = 1'b0; idle(3);
        src[0] = 1'b1; tick();
        src[0] = 1'b0; idle(5);
        check("edge_irq0", 32'(irq), 32'd0);
        rd("edge_pend", 'h00, v);   check("edge_pend_c", v, 32'h01);
        wr('h10, 32'd1);
        tick();
        check("edge_irq1", 32'(irq), 32'd1);
        rd("edge_claim2", 'h10, v); check("edge_claim2_c", v, 32'd1);
        wr('h10, 32'd1);
        idle(2);

        // Level mode held high through service
        wr('h08, 32'h00);
        wr('h04, 32'h10);
        wr('h30, 32'd2);
        src[4] = 1'b1;
        idle(5);
        rd("lvl_claim", 'h10, v);  check("lvl_claim_c", v, 32'd5);
        idle(4);
        rd("lvl_pend", 'h00, v);   check("lvl_pend_c", v, 32'd0);
        check("lvl_irq0", 32'(irq), 32'd0);
        wr('h10, 32'd7);
        wr('h10, 32'd0);
        idle(2);
        check("lvl_bad_cmp", 32'(irq), 32'd0);
        wr('h10, 32'd5);
        idle(2);
        check("lvl_reassert", 32'(irq), 32'd1);

        // Reset in the middle of service
        rd("mid_claim", 'h10, v);  check("mid_claim_c", v, 32'd5);
        wr('h04, 32'h11);
        src[0] = 1'b1;
        idle(5);
        check("mid_irq1", 32'(irq), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_irq", 32'(irq), 32'd0);
        rd("mid_pend", 'h00, v);   check("mid_pend_c", v, 32'd0);
        rd("mid_en", 'h04, v);     check("mid_en_c", v, 32'd0);
        wr('h04, 32'h10);
        wr('h30, 32'd2);
        idle(3);
        rd("mid_svc", 'h10, v);    check("mid_svc_c", v, 32'd5);
        wr('h10, 32'd5);

        // Randomized bus traffic and source activity
        for (int k = 0; k < 400; k++) begin
            int unsigned r;
            int unsigned b;
            r   = $urandom_range(0, 99);
            mrd = 1'b0; mwr = 1'b0; rst = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                b = $urandom_range(0, N - 1);
                src[b] = ~src[b];
            end
            adr  = BASE + 32'(offs[$urandom_range(0, 11)]);
            if ($urandom_range(0, 9) == 0) adr = adr + 32'h100;
            d_in = $urandom();
            if (r < 30)       mrd = 1'b1;
            else if (r < 55)  mwr = 1'b1;
            else if (r < 60)  begin mrd = 1'b1; mwr = 1'b1; end
            else if (r < 62)  rst = 1'b0;
            if (adr[7:0] == 8'h10 && mwr) d_in = 32'($urandom_range(0, 9));
            #1;
            check("rand_dout", d_out, model_read(adr, mrd));
            tick();
        end
        mrd = 1'b0; mwr = 1'b0; rst = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ext_irq_controller.md
Name: ext_irq_controller

Overview:
- Parametrised machine-level external interrupt controller (PLIC-lite) for the RV32I trap pipeline.
- Replaces the single hand-driven machine_external_interrupt wire with NUM_SRC synchronised sources. Each source has its own enable, edge/level mode and priority, plus a global threshold.
- The core reads CLAIM to get the winning source ID and writes COMPLETE to release it.
- Sits on the data-memory bus beside data_mem, decoded by address; its output drives riscv_pipeline.machine_external_interrupt.

Parameters:
- NUM_SRC, 8, number of sources (1..31). Source src[i] has ID i+1; ID 0 means "none".
- PRIO_W, 3, priority width. Priority 0 means never eligible.
- BASE_ADR, 32'h0000_4000, byte base of the register window. The window is 256 bytes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: the block resets on a rising edge of clk while rst==0.
- src  in  NUM_SRC  asynchronous interrupt request lines.
- adr  in  32  bus byte address. The block is selected when adr[31:8]==BASE_ADR[31:8]; the register is chosen by adr[7:2].
- d_in  in  32  write data.
- mrd  in  1  read strobe.
- mwr  in  1  write strobe.
- d_out  out  32  read data. Combinational from the current state; 0 when not selected or when mrd==0.
- machine_external_interrupt  out  1  registered interrupt request to the core.

Behaviour:
- Register map (byte offsets):
  - 0x00 PENDING: read-only, bit i = pending of source ID i+1.
  - 0x04 ENABLE: read/write.
  - 0x08 MODE: read/write, 1 = edge, 0 = level.
  - 0x0C THRESHOLD: read/write, PRIO_W bits.
  - 0x10 CLAIM/COMPLETE.
  - 0x20+4*i PRIORITY[i]: read/write, PRIO_W bits, zero-extended on read.
  - Unmapped offsets read 0 and ignore writes. Write bits above the field width are dropped.
- Reset (rst==0 at a clk edge) clears every register: pending, in_service, ENABLE, MODE, THRESHOLD, all PRIORITY, sync flops and machine_external_interrupt. Reset wins over any concurrent bus access or source activity.
- Synchroniser: each src bit passes through 2 flops (s1, s2). s2_d, a third flop holding s2 delayed by one cycle, feeds the edge detector: edge = s2 & ~s2_d.
- Pending set, edge mode: an edge sets pending. This also happens while the source is in service; the request is held and becomes eligible after COMPLETE.
- Pending set, level mode: pending follows s2 while the source is not in service. While in service, pending is held at 0.
- Eligibility: a source is eligible when enable, pending and !in_service are all 1 and priority > THRESHOLD.
- Winner: the highest-priority eligible source. On a tie, the lowest ID wins. Winner ID is 0 if nothing is eligible.
- machine_external_interrupt is registered and equals (winner != 0) from the previous cycle.
- Latency: src rises before edge k; s1 at k, s2 at k+1, pending at k+2, machine_external_interrupt=1 after edge k+3. The minimum is therefore 4 edges.
- CLAIM read (mrd==1 at offset 0x10):
  - d_out returns the current winner ID (zero-extended).
  - At the next rising edge, if the ID is non-zero: that source's pending is cleared and its in_service is set.
  - An edge arriving at that same clock edge on the claimed source sets pending again; set wins over claim-clear.
  - Claim side effects occur once per cycle in which mrd is high.
- COMPLETE write (mwr==1 at offset 0x10): clears in_service of ID d_in[4:0]. Writes are ignored when the ID is 0, greater than NUM_SRC, or not in service.
- mrd and mwr both high: the write is performed and read side effects (claim) are suppressed. d_out is still driven.
- Changes to ENABLE, PRIORITY or THRESHOLD take effect on the winner in the next cycle. Disabling a source does not clear its pending.
- Level-mode source dropping before claim: pending clears, so a spurious claim can return 0. Returning 0 from CLAIM has no side effect.

Decomposition:
- Package ext_irq_pkg: register offset constants, MODE_EDGE/MODE_LEVEL encodings, and an ID width function clog2(NUM_SRC+1).
- Sub-module ext_irq_src_cell, instantiated once per source. It contains the sync flops, edge detect, pending and in_service flops, and claim/complete inputs, and it outputs eligible.
- The top level holds the register file, the priority arbiter (a linear scan loop) and the bus decode.

Test Plan:
- Reset with rst=0 for 2 cycles while src=8'hFF: all registers read 0 and machine_external_interrupt=0. Then set ENABLE=8'h01, PRIORITY[0]=1, MODE=0: irq=1 exactly 4 edges after src[0] rises.
- Set PRIORITY[2]=5, PRIORITY[5]=5, PRIORITY[1]=7 and raise src 1, 2 and 5. CLAIM must return 2, then 3 and 6 in that order (each completed before the next claim).
- THRESHOLD=4 with PRIORITY[3]=4 and src[3] active: irq stays 0 and CLAIM returns 0. Then set THRESHOLD=3: irq=1 two cycles later.
- Edge mode on src[0]: claim returns 1; pulse src[0] again while in service; irq stays 0 until COMPLETE is written with 1, then irq=1 and a second claim returns 1.
- Level mode: src[4] held high, claim returns 5, and no re-pend occurs until COMPLETE. After COMPLETE with src still high, irq reasserts. COMPLETE with 7 (not in service) and with 0 changes nothing.
- Apply rst=0 mid-service, with in_service set and irq=1: after one edge, PENDING, in_service and irq are all 0, and ENABLE reads 0.
